// File: rtl/qea_host_ctrl_pkg.sv
// Shared definitions for the QEA host controller: FSM encoding and
// fixed-point constants used when building the initial state vector.
package qea_host_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_CTX   = 3'd1,
    ST_INIT_STATE = 3'd2,
    ST_START      = 3'd3,
    ST_WAIT       = 3'd4,
    ST_READ       = 3'd5,
    ST_DONE       = 3'd6
  } qea_state_e;

  // Amplitude 1.0 in Q2.30
  localparam logic signed [31:0] Q230_ONE = 32'sh4000_0000;

  // Smallest legal register: one state word holds four amplitudes
  localparam int unsigned MIN_QBIT = 2;

endpackage

// File: rtl/qea_skid_fifo.sv
// Two-entry FIFO decoupling QEA state reads from the downstream result
// stream. The producer must never push while the FIFO is full.
module qea_skid_fifo #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  output logic         vld_o,
  input  logic         rdy_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   cnt_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         pop;

  assign pop = (cnt_q != 2'd0) && rdy_i;

  // Pointer and occupancy tracking; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop)    rd_ptr_q <= ~rd_ptr_q;
      case ({push_i, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array, written on push only
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign vld_o  = (cnt_q != 2'd0);
  // Gate data with valid so stale words never appear after a flush
  assign dout_o = vld_o ? mem_q[rd_ptr_q] : '0;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/qea_host_ctrl.sv
// Host-side job sequencer for the QEA: loads gate context, initialises the
// state vector to |0>, starts the accelerator, times it, then streams the
// resulting state vector out through a skid FIFO.
module qea_host_ctrl
  import qea_host_ctrl_pkg::*;
#(
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int CYC_WIDTH               = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_run,
  input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_ins_num,
  input  logic                               i_ctx_valid,
  output logic                               o_ctx_ready,
  input  logic [2*DATA_WIDTH-1:0]            i_ctx_data,
  output logic                               o_ctx_en,
  output logic                               o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr,
  output logic [2*DATA_WIDTH-1:0]            o_ctx_data,
  output logic                               o_state_ena,
  output logic                               o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]        o_state_addra,
  output logic [PE_NUM*2*DATA_WIDTH-1:0]     o_state_dina,
  output logic                               o_start,
  input  logic                               i_complete,
  input  logic [PE_NUM*2*DATA_WIDTH-1:0]     i_state_dout,
  output logic                               o_rd_valid,
  input  logic                               i_rd_ready,
  output logic [PE_NUM*2*DATA_WIDTH-1:0]     o_rd_data,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_err,
  output logic [CYC_WIDTH-1:0]               o_cycles
);

  localparam int SW  = 2 * DATA_WIDTH;
  localparam int OW  = PE_NUM * SW;
  localparam int AW1 = STATE_ADDR_WIDTH + 1;

  localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_LO = MAX_QBIT_WIDTH'(MIN_QBIT);
  localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_HI = MAX_QBIT_WIDTH'(MIN_QBIT + STATE_ADDR_WIDTH);

  // |0> amplitude: real = 1.0, imag = 0, placed in the most-significant slot
  localparam logic signed [DATA_WIDTH-1:0] ONE_RE    = DATA_WIDTH'(Q230_ONE);
  localparam logic [SW-1:0]                ONE_AMP   = {ONE_RE, {DATA_WIDTH{1'b0}}};
  localparam logic [OW-1:0]                INIT_WORD = OW'(ONE_AMP) << ((PE_NUM - 1) * SW);

  function automatic logic [CYC_WIDTH-1:0] sat_inc(input logic [CYC_WIDTH-1:0] v);
    return (&v) ? v : v + CYC_WIDTH'(1);
  endfunction

  qea_state_e state_q, state_d;

  logic [MAX_QBIT_WIDTH-1:0]          qbit_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_cnt_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_addr_q;
  logic [SW-1:0]                      ctx_data_q;
  logic                               ctx_en_q;
  // One extra bit so D = 2**STATE_ADDR_WIDTH is representable
  logic [AW1-1:0]                     addr_cnt_q;
  logic [AW1-1:0]                     acc_cnt_q;
  logic [AW1-1:0]                     depth;
  logic [AW1-1:0]                     last_addr;
  logic [CYC_WIDTH-1:0]               cyc_q;
  logic                               err_q;
  logic                               rd_dv_q;

  logic run_take, qbit_ok, ctx_rdy, ctx_acc, init_wr, rd_iss, rd_pop;

  logic          fifo_vld;
  logic [OW-1:0] fifo_dout;
  logic [1:0]    fifo_cnt;

  assign qbit_ok   = (qbit_q >= QBIT_LO) && (qbit_q <= QBIT_HI);
  assign depth     = AW1'(1) << (qbit_q - QBIT_LO);
  assign last_addr = depth - AW1'(1);
  assign rd_pop    = fifo_vld && i_rd_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and per-state strobe decode
  always_comb begin
    state_d  = state_q;
    run_take = 1'b0;
    ctx_rdy  = 1'b0;
    ctx_acc  = 1'b0;
    init_wr  = 1'b0;
    rd_iss   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_run) begin
          run_take = 1'b1;
          state_d  = ST_LOAD_CTX;
        end
      end
      ST_LOAD_CTX: begin
        if (!qbit_ok) begin
          state_d = ST_DONE;
        end else if (ins_q == '0) begin
          state_d = ST_INIT_STATE;
        end else begin
          ctx_rdy = 1'b1;
          ctx_acc = i_ctx_valid;
          if (i_ctx_valid && (ctx_cnt_q == ins_q - 1'b1)) state_d = ST_INIT_STATE;
        end
      end
      ST_INIT_STATE: begin
        init_wr = 1'b1;
        if (addr_cnt_q == last_addr) state_d = ST_START;
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_complete) state_d = ST_READ;
      end
      ST_READ: begin
        // A read is only issued if the FIFO can absorb it plus any read in flight
        rd_iss = (addr_cnt_q < depth) && ((fifo_cnt + {1'b0, rd_dv_q}) < 2'd2);
        if (rd_pop && (acc_cnt_q == last_addr)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Job parameters captured on i_run
  always_ff @(posedge clk) begin
    if (run_take) begin
      qbit_q <= i_qbit_num;
      ins_q  <= i_ins_num;
    end
  end

  // Counters, status and registered context-write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      ctx_cnt_q  <= '0;
      ctx_addr_q <= '0;
      ctx_data_q <= '0;
      ctx_en_q   <= 1'b0;
      addr_cnt_q <= '0;
      acc_cnt_q  <= '0;
      cyc_q      <= '0;
      err_q      <= 1'b0;
      rd_dv_q    <= 1'b0;
    end else begin
      ctx_en_q <= ctx_acc;
      rd_dv_q  <= rd_iss;
      if (run_take) begin
        ctx_cnt_q  <= '0;
        addr_cnt_q <= '0;
        acc_cnt_q  <= '0;
        cyc_q      <= '0;
        err_q      <= 1'b0;
      end
      if ((state_q == ST_LOAD_CTX) && !qbit_ok) err_q <= 1'b1;
      if (ctx_acc) begin
        ctx_cnt_q  <= ctx_cnt_q + 1'b1;
        ctx_addr_q <= ctx_cnt_q;
        ctx_data_q <= i_ctx_data;
      end
      if (init_wr || rd_iss) addr_cnt_q <= addr_cnt_q + 1'b1;
      // The cycle counted as START is the reference point; every WAIT
      // cycle, including the one that sees i_complete, adds one.
      if (state_q == ST_START) begin
        addr_cnt_q <= '0;
        cyc_q      <= '0;
      end
      if (state_q == ST_WAIT) cyc_q <= sat_inc(cyc_q);
      if ((state_q == ST_READ) && rd_pop) acc_cnt_q <= acc_cnt_q + 1'b1;
    end
  end

  qea_skid_fifo #(
    .W (OW)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .push_i (rd_dv_q),
    .din_i  (i_state_dout),
    .vld_o  (fifo_vld),
    .rdy_i  (i_rd_ready),
    .dout_o (fifo_dout),
    .cnt_o  (fifo_cnt)
  );

  assign o_ctx_ready   = ctx_rdy;
  assign o_ctx_en      = ctx_en_q;
  assign o_ctx_wea     = ctx_en_q;
  assign o_ctx_addr    = ctx_addr_q;
  assign o_ctx_data    = ctx_data_q;
  assign o_state_ena   = init_wr | rd_iss;
  assign o_state_wea   = init_wr;
  assign o_state_addra = (init_wr | rd_iss) ? addr_cnt_q[STATE_ADDR_WIDTH-1:0] : '0;
  assign o_state_dina  = (init_wr && (addr_cnt_q == '0)) ? INIT_WORD : '0;
  assign o_start       = (state_q == ST_START);
  assign o_busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign o_done        = (state_q == ST_DONE);
  assign o_err         = err_q;
  assign o_cycles      = cyc_q;
  assign o_rd_valid    = fifo_vld;
  assign o_rd_data     = fifo_dout;

endmodule

// File: tb/tb_qea_host_ctrl.sv
// Directed testbench for qea_host_ctrl with a simple QEA state-RAM model.
`timescale 1ns/1ps
module tb_qea_host_ctrl;

  localparam int W = 256;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_run;
  logic [5:0]     i_qbit_num;
  logic [15:0]    i_ins_num;
  logic           i_ctx_valid;
  logic           o_ctx_ready;
  logic [63:0]    i_ctx_data;
  logic           o_ctx_en, o_ctx_wea;
  logic [15:0]    o_ctx_addr;
  logic [63:0]    o_ctx_data;
  logic           o_state_ena, o_state_wea;
  logic [15:0]    o_state_addra;
  logic [W-1:0]   o_state_dina;
  logic           o_start;
  logic           i_complete;
  logic [W-1:0]   i_state_dout;
  logic           o_rd_valid;
  logic           i_rd_ready;
  logic [W-1:0]   o_rd_data;
  logic           o_busy, o_done, o_err;
  logic [31:0]    o_cycles;

  qea_host_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_run         (i_run),
    .i_qbit_num    (i_qbit_num),
    .i_ins_num     (i_ins_num),
    .i_ctx_valid   (i_ctx_valid),
    .o_ctx_ready   (o_ctx_ready),
    .i_ctx_data    (i_ctx_data),
    .o_ctx_en      (o_ctx_en),
    .o_ctx_wea     (o_ctx_wea),
    .o_ctx_addr    (o_ctx_addr),
    .o_ctx_data    (o_ctx_data),
    .o_state_ena   (o_state_ena),
    .o_state_wea   (o_state_wea),
    .o_state_addra (o_state_addra),
    .o_state_dina  (o_state_dina),
    .o_start       (o_start),
    .i_complete    (i_complete),
    .i_state_dout  (i_state_dout),
    .o_rd_valid    (o_rd_valid),
    .i_rd_ready    (i_rd_ready),
    .o_rd_data     (o_rd_data),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err),
    .o_cycles      (o_cycles)
  );

  always #5 clk = ~clk;

  localparam logic [W-1:0] INIT_EXP = {64'h4000_0000_0000_0000, 192'h0};

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor counters
  int ctx_wr_cnt, ctx_bad, st_wr_cnt, st_bad, rd_iss_cnt, rd_bad;
  int start_cnt, res_cnt, res_bad;
  bit stall_prev;
  logic [W-1:0] stall_data;
  bit rd_req;
  logic [15:0] rd_req_addr;

  function automatic logic [63:0] ctx_word(input int k);
    return {32'hC0C0_0000 + 32'(k), 32'h0F0F_0000 ^ 32'(k)};
  endfunction

  function automatic logic [W-1:0] dout_word(input int a);
    return {32'hFACE_0000 + 32'(a), 160'h0, 64'h1234_5678_0000_0000 | 64'(a)};
  endfunction

  task automatic check_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters();
    ctx_wr_cnt = 0; ctx_bad = 0; st_wr_cnt = 0; st_bad = 0;
    rd_iss_cnt = 0; rd_bad = 0; start_cnt = 0; res_cnt = 0; res_bad = 0;
    stall_prev = 0;
  endtask

  // Observe DUT strobes and the result stream once per cycle
  initial begin
    clear_counters();
    rd_req = 0;
    rd_req_addr = '0;
    forever begin
      @(negedge clk);
      if (o_ctx_en) begin
        if (!o_ctx_wea || o_ctx_addr != 16'(ctx_wr_cnt) || o_ctx_data != ctx_word(ctx_wr_cnt)) ctx_bad++;
        ctx_wr_cnt++;
      end
      if (o_state_ena && o_state_wea) begin
        if (o_state_addra != 16'(st_wr_cnt) || o_state_dina != ((st_wr_cnt == 0) ? INIT_EXP : '0)) st_bad++;
        st_wr_cnt++;
      end
      if (o_state_ena && !o_state_wea) begin
        if (o_state_addra != 16'(rd_iss_cnt)) rd_bad++;
        rd_iss_cnt++;
        rd_req = 1;
        rd_req_addr = o_state_addra;
      end else begin
        rd_req = 0;
      end
      if (o_start) start_cnt++;
      if (stall_prev && (!o_rd_valid || o_rd_data != stall_data)) res_bad++;
      if (o_rd_valid && i_rd_ready) begin
        if (o_rd_data != dout_word(res_cnt)) res_bad++;
        res_cnt++;
      end
      stall_prev = o_rd_valid && !i_rd_ready;
      stall_data = o_rd_data;
    end
  end

  // State RAM read model: data appears one cycle after the read strobe
  initial begin
    i_state_dout = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_req) i_state_dout = dout_word(int'(rd_req_addr));
    end
  end

  // Watchdog against a hung run
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_run(input int qb, input int ins);
    i_qbit_num = 6'(qb);
    i_ins_num  = 16'(ins);
    i_run = 1'b1;
    step();
    i_run = 1'b0;
  endtask

  task automatic feed_ctx(input int n, input bit tog, input string tag);
    int k;
    int c;
    bit ph;
    bit acc;
    k = 0; c = 0; ph = 1'b1;
    while (k < n && c < 4 * n + 20) begin
      i_ctx_valid = tog ? ph : 1'b1;
      i_ctx_data  = ctx_word(k);
      @(negedge clk);
      acc = i_ctx_valid && o_ctx_ready;
      step();
      if (acc) k++;
      ph = !ph;
      c++;
    end
    i_ctx_valid = 1'b0;
    check_int({tag, " ctx_accepted"}, k, n);
  endtask

  task automatic wait_start(input string tag);
    bit ok;
    ok = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (o_start) begin ok = 1; break; end
    end
    check_int({tag, " start_seen"}, int'(ok), 1);
    check_int({tag, " busy_at_start"}, int'(o_busy), 1);
  endtask

  task automatic run_job(input int qb, input int ins, input bit tog, input int cdel,
                         input bit rnd, input string tag);
    int d;
    bit ok;
    d = 1 << (qb - 2);
    clear_counters();
    pulse_run(qb, ins);
    feed_ctx(ins, tog, tag);
    wait_start(tag);
    repeat (cdel - 1) @(posedge clk);
    @(negedge clk);
    check_int({tag, " wait_strobes_low"}, int'({o_state_ena, o_ctx_en, o_start}), 0);
    @(posedge clk);
    #1;
    i_complete = 1'b1;
    step();
    i_complete = 1'b0;
    ok = 0;
    for (int c = 0; c < 20000; c++) begin
      i_rd_ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
      @(negedge clk);
      if (o_done) begin ok = 1; break; end
      step();
    end
    i_rd_ready = 1'b1;
    check_int({tag, " done_seen"}, int'(ok), 1);
    check_int({tag, " ctx_writes"}, ctx_wr_cnt, ins);
    check_int({tag, " ctx_bad"}, ctx_bad, 0);
    check_int({tag, " state_writes"}, st_wr_cnt, d);
    check_int({tag, " state_bad"}, st_bad, 0);
    check_int({tag, " start_pulses"}, start_cnt, 1);
    check_int({tag, " cycles"}, int'(o_cycles), cdel);
    check_int({tag, " reads_issued"}, rd_iss_cnt, d);
    check_int({tag, " read_addr_bad"}, rd_bad, 0);
    check_int({tag, " results"}, res_cnt, d);
    check_int({tag, " result_bad"}, res_bad, 0);
    check_int({tag, " busy_done"}, int'({o_busy, o_done, o_err}), 3'b010);
    step();
  endtask

  task automatic run_err(input int qb, input string tag);
    bit ok;
    clear_counters();
    pulse_run(qb, 4);
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_done) begin ok = 1; break; end
    end
    check_int({tag, " done_seen"}, int'(ok), 1);
    check_int({tag, " err"}, int'(o_err), 1);
    check_int({tag, " busy"}, int'(o_busy), 0);
    check_int({tag, " qea_strobes"}, ctx_wr_cnt + st_wr_cnt + rd_iss_cnt + start_cnt, 0);
    step();
  endtask

  initial begin
    rst = 1'b1; i_run = 1'b0; i_qbit_num = '0; i_ins_num = '0;
    i_ctx_valid = 1'b0; i_ctx_data = '0; i_complete = 1'b0; i_rd_ready = 1'b1;

    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check_vec("reset ctrl", W'({o_busy, o_done, o_err, o_start, o_ctx_ready, o_ctx_en, o_ctx_wea,
                                o_state_ena, o_state_wea, o_rd_valid}), '0);
    check_vec("reset data", W'({o_cycles, o_ctx_addr, o_ctx_data, o_state_addra}), '0);
    check_vec("reset rd_data", o_rd_data, '0);
    check_vec("reset dina", o_state_dina, '0);
    step();

    // Large job: 163 context words, 512 state words, 100-cycle execution
    run_job(11, 163, 1'b0, 100, 1'b0, "jobA");

    // Small job: bursty context source and bursty result sink
    run_job(3, 5, 1'b1, 5, 1'b1, "jobB");

    // Out-of-range qubit counts on both sides
    run_err(1, "err_q1");
    run_err(19, "err_q19");

    // Reset while the QEA is running
    clear_counters();
    pulse_run(2, 1);
    feed_ctx(1, 1'b0, "rstmid");
    wait_start("rstmid");
    repeat (3) step();
    check_int("rstmid cycles_before_rst", int'(o_cycles), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_vec("rstmid ctrl", W'({o_busy, o_done, o_err, o_start, o_ctx_ready, o_ctx_en, o_ctx_wea,
                                 o_state_ena, o_state_wea, o_rd_valid}), '0);
    check_vec("rstmid data", W'({o_cycles, o_ctx_addr, o_ctx_data, o_state_addra}), '0);
    check_vec("rstmid rd_data", o_rd_data, '0);
    step();

    // Recovery job with no context words
    run_job(2, 0, 1'b0, 7, 1'b0, "recover");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
